// File: rtl/lc3_fetch_pkg.sv
// Shared opcode constants and fetch state encoding for the LC3 prefetching fetch unit.
package lc3_fetch_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_queue.sv
// Synchronous FIFO of {pc, instr} pairs; flush clears occupancy and wins over push/pop.
module lc3_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head       = mem[rd_ptr];
  assign head_valid = (cnt != '0);
  assign count      = cnt;

endmodule

// File: rtl/lc3_fetch_pq.sv
// LC3 fetch unit: issues one-cycle-latency instruction reads into a prefetch queue and
// redirects on resolved BR/JMP, stops on HALT, resumes on fetch_start.
module lc3_fetch_pq
  import lc3_fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 16,
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_start,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [DATA_W-1:0]       instr_out,
  output logic [ADDR_W-1:0]       instr_pc,
  input  logic                    resolve_valid,
  input  logic [3:0]              opCode_in,
  input  logic [8:0]              offset_in,
  input  logic [ADDR_W-1:0]       reg_in,
  input  logic [2:0]              br_nzp,
  input  logic [2:0]              result_nzp,
  input  logic [ADDR_W-1:0]       resolve_pc,
  output logic [ADDR_W-1:0]       pc,
  output logic                    halted,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned QW = ADDR_W + DATA_W;

  fetch_state_t        state, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt;
  logic                inflight, inflight_nxt;
  logic [ADDR_W-1:0]   issue_addr;

  logic [CW-1:0]       q_count;
  logic [QW-1:0]       q_head;
  logic                q_valid;

  logic                br_taken;
  logic                jmp_taken;
  logic                halt_res;
  logic                flush;
  logic                pop;
  logic signed [8:0]   offset_s;
  logic [ADDR_W-1:0]   br_target;

  // Credit counts the in-flight read so a returning word always has a free slot.
  assign mem_rd   = (state == FETCH) &&
                    (({1'b0, q_count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign mem_addr = pc_q;

  always_comb begin
    offset_s  = offset_in;
    br_target = resolve_pc + ADDR_W'(offset_s);
    br_taken  = resolve_valid && (opCode_in == OP_BR) && ((br_nzp & result_nzp) != 3'b000);
    jmp_taken = resolve_valid && (opCode_in == OP_JMP);
    halt_res  = resolve_valid && (opCode_in == OP_HALT);
    flush     = br_taken || jmp_taken || halt_res;
    pop       = q_valid && instr_ready;
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    // A read issued in a flushing cycle is killed so its data is never pushed.
    inflight_nxt = mem_rd && !flush;
    if (halt_res) begin
      state_nxt = HALT;
      pc_nxt    = resolve_pc;
    end else begin
      if (fetch_start && (state != FETCH)) state_nxt = FETCH;
      if (br_taken)       pc_nxt = br_target;
      else if (jmp_taken) pc_nxt = reg_in;
      else if (mem_rd)    pc_nxt = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      inflight   <= 1'b0;
      issue_addr <= '0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      inflight <= inflight_nxt;
      if (mem_rd) issue_addr <= pc_q;
    end
  end

  lc3_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .push_data  ({issue_addr, mem_rdata}),
    .pop        (pop),
    .flush      (flush),
    .head       (q_head),
    .head_valid (q_valid),
    .count      (q_count)
  );

  assign instr_valid = q_valid;
  assign instr_out   = q_valid ? q_head[DATA_W-1:0]  : '0;
  assign instr_pc    = q_valid ? q_head[QW-1:DATA_W] : '0;
  assign pc          = pc_q;
  assign halted      = (state == HALT);
  assign count       = q_count;

endmodule

// File: tb/tb_lc3_fetch_pq.sv
// Directed bench for lc3_fetch_pq with a one-cycle memory model and an issue/pop scoreboard.
module tb_lc3_fetch_pq;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        resolve_valid;
  logic [3:0]  opCode_in;
  logic [8:0]  offset_in;
  logic [15:0] reg_in;
  logic [2:0]  br_nzp;
  logic [2:0]  result_nzp;
  logic [15:0] resolve_pc;
  logic [15:0] pc;
  logic        halted;
  logic [2:0]  count;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned rd_cnt   = 0;
  logic [15:0] exp_addr = '0;
  logic [31:0] exp_q[$];
  logic        found;

  lc3_fetch_pq #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .resolve_valid(resolve_valid),
    .opCode_in(opCode_in), .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp),
    .result_nzp(result_nzp), .resolve_pc(resolve_pc), .pc(pc), .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mdata(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue monitor pushes expected pairs; pop monitor compares the head on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        check("rd_addr", {16'h0, mem_addr}, {16'h0, exp_addr});
        exp_q.push_back({exp_addr, mdata(exp_addr)});
        exp_addr = exp_addr + 16'd1;
        rd_cnt++;
      end
      if (instr_valid && instr_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL sb_underflow observed_pc=%0h expected=none", instr_pc);
        end
        if (exp_q.size() > 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("pop_pc", {16'h0, instr_pc}, {16'h0, e[31:16]});
          check("pop_instr", {16'h0, instr_out}, {16'h0, e[15:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_start = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0;
    opCode_in = 4'b1111; offset_in = '0; reg_in = '0; br_nzp = '0; result_nzp = '0;
    resolve_pc = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("rst_pc", {16'h0, pc}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_count", {29'h0, count}, 32'h0);
    check("rst_instr_out", {16'h0, instr_out}, 32'h0);

    // Fill with decode stalled: exactly DEPTH reads.
    rd_cnt = 0;
    @(posedge clk); #1 fetch_start = 1'b1;
    @(posedge clk); #1 fetch_start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("fill_reads", rd_cnt, 32'd4);
    check("fill_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("fill_count", {29'h0, count}, 32'd4);
    check("fill_head_pc", {16'h0, instr_pc}, 32'h0);
    check("fill_head_instr", {16'h0, instr_out}, {16'h0, mdata(16'h0000)});
    check("fill_valid", {31'h0, instr_valid}, 32'h1);

    // Stream, then a taken BR back to 0x0003 with a read in flight.
    @(posedge clk); #1 instr_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 resolve_valid = 1'b1; opCode_in = 4'b0000; br_nzp = 3'b010; result_nzp = 3'b010;
    resolve_pc = 16'h0005; offset_in = 9'h1FE;
    @(posedge clk); #1 resolve_valid = 1'b0;
    exp_q.delete(); exp_addr = 16'h0003;
    @(negedge clk);
    check("br_count", {29'h0, count}, 32'h0);
    check("br_valid", {31'h0, instr_valid}, 32'h0);
    check("br_mem_addr", {16'h0, mem_addr}, 32'h0003);
    check("br_mem_rd", {31'h0, mem_rd}, 32'h1);
    @(negedge clk);
    check("br_stale_count", {29'h0, count}, 32'h0);
    check("br_stale_valid", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    check("br_first_valid", {31'h0, instr_valid}, 32'h1);
    check("br_first_pc", {16'h0, instr_pc}, 32'h0003);

    // Same BR with non-matching condition codes: no effect.
    repeat (3) @(posedge clk);
    #1 resolve_valid = 1'b1; result_nzp = 3'b100;
    @(posedge clk); #1 resolve_valid = 1'b0;
    @(negedge clk);
    check("brnt_count", {29'h0, count}, 32'h1);
    check("brnt_valid", {31'h0, instr_valid}, 32'h1);

    // JMP to 0x4000 while streaming.
    repeat (2) @(posedge clk);
    #1 resolve_valid = 1'b1; opCode_in = 4'b1100; reg_in = 16'h4000;
    @(posedge clk); #1 resolve_valid = 1'b0;
    exp_q.delete(); exp_addr = 16'h4000;
    @(negedge clk);
    check("jmp_mem_addr", {16'h0, mem_addr}, 32'h4000);
    check("jmp_mem_rd", {31'h0, mem_rd}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("jmp_first_valid", {31'h0, instr_valid}, 32'h1);
    check("jmp_first_pc", {16'h0, instr_pc}, 32'h4000);

    // HALT resolve coinciding with fetch_start: HALT wins.
    repeat (2) @(posedge clk);
    #1 resolve_valid = 1'b1; opCode_in = 4'b1111; resolve_pc = 16'h0010; fetch_start = 1'b1;
    @(posedge clk); #1 resolve_valid = 1'b0; fetch_start = 1'b0;
    exp_q.delete(); exp_addr = 16'h0010;
    @(negedge clk);
    check("halt_halted", {31'h0, halted}, 32'h1);
    check("halt_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("halt_count", {29'h0, count}, 32'h0);
    check("halt_pc", {16'h0, pc}, 32'h0010);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("halt_hold_count", {29'h0, count}, 32'h0);
    check("halt_hold_rd", {31'h0, mem_rd}, 32'h0);
    @(posedge clk); #1 fetch_start = 1'b1;
    @(posedge clk); #1 fetch_start = 1'b0;
    @(negedge clk);
    check("resume_mem_rd", {31'h0, mem_rd}, 32'h1);
    check("resume_mem_addr", {16'h0, mem_addr}, 32'h0010);
    check("resume_halted", {31'h0, halted}, 32'h0);

    // Stall decode until three entries are queued with one read in flight, then reset.
    repeat (3) @(posedge clk);
    #1 instr_ready = 1'b0;
    found = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (count == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("pre_rst_count", {29'h0, count}, 32'd3);
    #1 rst = 1'b1;
    exp_q.delete(); exp_addr = 16'h0000;
    #1;
    check("mid_rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("mid_rst_pc", {16'h0, pc}, 32'h0);
    check("mid_rst_mem_rd", {31'h0, mem_rd}, 32'h0);
    check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    check("mid_rst_count", {29'h0, count}, 32'h0);
    check("mid_rst_instr_pc", {16'h0, instr_pc}, 32'h0);
    check("mid_rst_halted", {31'h0, halted}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_count", {29'h0, count}, 32'h0);
    check("post_rst_valid", {31'h0, instr_valid}, 32'h0);
    check("post_rst_mem_rd", {31'h0, mem_rd}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
